// File: rtl/histo_readout_if.sv
// Bundle of the readout stage's histogram read port, output stream and sweep summary.
// master = the readout block itself, slave = the histogram/consumer side.
interface histo_readout_if #(
    parameter int BIN_W   = 4,
    parameter int COUNT_W = 10
);
    logic                     start;
    logic [BIN_W-1:0]         addr;
    logic [COUNT_W-1:0]       hist_data;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [BIN_W-1:0]         out_bin;
    logic [COUNT_W-1:0]       out_count;
    logic [BIN_W-1:0]         peak_bin;
    logic [COUNT_W-1:0]       peak_count;
    logic [COUNT_W+BIN_W-1:0] total_count;
    logic                     done;

    modport master (
        input  start, hist_data, out_ready,
        output addr, busy, out_valid, out_bin, out_count,
               peak_bin, peak_count, total_count, done
    );

    modport slave (
        output start, hist_data, out_ready,
        input  addr, busy, out_valid, out_bin, out_count,
               peak_bin, peak_count, total_count, done
    );
endinterface

// File: rtl/histo_readout.sv
// Sweeps every histogram bin once per start, streams (bin, count) pairs with
// valid/ready, and publishes the peak bin and total count when the sweep ends.
module histo_readout #(
    parameter int NUM_BINS  = 16,
    parameter int COUNT_W   = 10,
    parameter int SKIP_ZERO = 0
) (
    input  logic            clk,
    input  logic            rst,
    histo_readout_if.master bus
);
    localparam int BIN_W = $clog2(NUM_BINS);
    localparam int SUM_W = COUNT_W + BIN_W;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, PRESENT, FINISH} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   addr_q, addr_d;
    logic [BIN_W-1:0]   out_bin_q, out_bin_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;
    logic [BIN_W-1:0]   run_peak_bin_q, run_peak_bin_d;
    logic [COUNT_W-1:0] run_peak_count_q, run_peak_count_d;
    logic [SUM_W-1:0]   run_sum_q, run_sum_d;
    logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
    logic [COUNT_W-1:0] peak_count_q, peak_count_d;
    logic [SUM_W-1:0]   total_count_q, total_count_d;
    logic               last_bin;

    assign last_bin = (bin_q == BIN_W'(NUM_BINS - 1));

    always_comb begin
        state_d          = state_q;
        bin_d            = bin_q;
        addr_d           = addr_q;
        out_bin_d        = out_bin_q;
        out_count_d      = out_count_q;
        run_peak_bin_d   = run_peak_bin_q;
        run_peak_count_d = run_peak_count_q;
        run_sum_d        = run_sum_q;
        peak_bin_d       = peak_bin_q;
        peak_count_d     = peak_count_q;
        total_count_d    = total_count_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d            = '0;
                    run_peak_bin_d   = '0;
                    run_peak_count_d = '0;
                    run_sum_d        = '0;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                addr_d  = bin_q;
                state_d = WAIT;
            end
            WAIT: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                out_count_d = bus.hist_data;
                out_bin_d   = bin_q;
                run_sum_d   = run_sum_q + SUM_W'(bus.hist_data);
                // Strictly greater keeps the lower bin on ties.
                if (bus.hist_data > run_peak_count_q) begin
                    run_peak_bin_d   = bin_q;
                    run_peak_count_d = bus.hist_data;
                end
                if ((SKIP_ZERO != 0) && (bus.hist_data == '0)) begin
                    if (last_bin) begin
                        state_d = FINISH;
                    end else begin
                        bin_d   = bin_q + 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (last_bin) begin
                        state_d = FINISH;
                    end else begin
                        bin_d   = bin_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Publish on entry to FINISH so the summary is already valid while done is high.
        if ((state_d == FINISH) && (state_q != FINISH)) begin
            peak_bin_d    = run_peak_bin_d;
            peak_count_d  = run_peak_count_d;
            total_count_d = run_sum_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            bin_q            <= '0;
            addr_q           <= '0;
            out_bin_q        <= '0;
            out_count_q      <= '0;
            run_peak_bin_q   <= '0;
            run_peak_count_q <= '0;
            run_sum_q        <= '0;
            peak_bin_q       <= '0;
            peak_count_q     <= '0;
            total_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            bin_q            <= bin_d;
            addr_q           <= addr_d;
            out_bin_q        <= out_bin_d;
            out_count_q      <= out_count_d;
            run_peak_bin_q   <= run_peak_bin_d;
            run_peak_count_q <= run_peak_count_d;
            run_sum_q        <= run_sum_d;
            peak_bin_q       <= peak_bin_d;
            peak_count_q     <= peak_count_d;
            total_count_q    <= total_count_d;
        end
    end

    assign bus.addr        = addr_q;
    assign bus.busy        = (state_q != IDLE) && (state_q != FINISH);
    assign bus.out_valid   = (state_q == PRESENT);
    assign bus.out_bin     = out_bin_q;
    assign bus.out_count   = out_count_q;
    assign bus.peak_bin    = peak_bin_q;
    assign bus.peak_count  = peak_count_q;
    assign bus.total_count = total_count_q;
    assign bus.done        = (state_q == FINISH);
endmodule

// File: tb/tb_histo_readout.sv
// Scoreboard bench: two readout instances (SKIP_ZERO 0 and 1) sweep a shared
// histogram model; expected pairs/summaries are queued at start and popped by a monitor.
module tb_histo_readout;
    localparam int NB = 16;
    localparam int CW = 10;
    localparam int BW = 4;
    localparam int SW = CW + BW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    histo_readout_if #(.BIN_W(BW), .COUNT_W(CW)) if0 ();
    histo_readout_if #(.BIN_W(BW), .COUNT_W(CW)) if1 ();

    histo_readout #(.NUM_BINS(NB), .COUNT_W(CW), .SKIP_ZERO(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.master));
    histo_readout #(.NUM_BINS(NB), .COUNT_W(CW), .SKIP_ZERO(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.master));

    // Histogram model: one-cycle registered read.
    logic [CW-1:0] mem [NB];
    always @(posedge clk) begin
        if0.hist_data <= mem[if0.addr];
        if1.hist_data <= mem[if1.addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;
    int ph    = 0;

    logic [BW+CW-1:0]        pair_q0[$], pair_q1[$];
    logic [BW+CW+SW-1:0]     sum_q0[$],  sum_q1[$];
    logic                    hold [2];
    logic [BW+CW-1:0]        held [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_both(input logic s);
        if0.start = s;
        if1.start = s;
    endtask

    // Consumer ready pattern, changed just after each posedge.
    always @(posedge clk) begin
        logic r;
        #1;
        case (mode)
            0:       r = 1'b1;
            1:       r = (ph == 0);
            default: r = 1'($urandom_range(0, 1));
        endcase
        ph = (ph + 1) % 4;
        if0.out_ready = r;
        if1.out_ready = r;
    end

    task automatic mon(input int d, input logic v, input logic rdy, input logic [BW-1:0] b,
                       input logic [CW-1:0] c, input logic dn, input logic bsy,
                       input logic [BW+CW+SW-1:0] summ);
        logic [BW+CW-1:0]    e;
        logic [BW+CW+SW-1:0] es;
        int                  left;
        if (hold[d]) begin
            check($sformatf("stall_valid%0d", d), 64'(v), 64'd1);
            check($sformatf("stall_pair%0d", d), 64'({b, c}), 64'(held[d]));
        end
        if (v && rdy) begin
            if ((d == 0 ? pair_q0.size() : pair_q1.size()) == 0) begin
                check($sformatf("extra_pair%0d", d), 64'({b, c}), 64'hFFFF_FFFF);
            end else begin
                e = (d == 0) ? pair_q0.pop_front() : pair_q1.pop_front();
                $display("dut%0d pair bin=%0d count=%0d (expect bin=%0d count=%0d)",
                         d, b, c, e[CW+BW-1:CW], e[CW-1:0]);
                check($sformatf("pair%0d", d), 64'({b, c}), 64'(e));
            end
        end
        hold[d] = v && !rdy;
        held[d] = {b, c};
        if (dn) begin
            check($sformatf("busy_at_done%0d", d), 64'(bsy), 64'd0);
            if ((d == 0 ? sum_q0.size() : sum_q1.size()) == 0) begin
                check($sformatf("unexpected_done%0d", d), 64'(summ), 64'hFFFF_FFFF_FFFF);
            end else begin
                es = (d == 0) ? sum_q0.pop_front() : sum_q1.pop_front();
                $display("dut%0d done peak_bin=%0d peak_count=%0d total=%0d", d,
                         summ[BW+CW+SW-1:CW+SW], summ[CW+SW-1:SW], summ[SW-1:0]);
                check($sformatf("summary%0d", d), 64'(summ), 64'(es));
            end
            left = (d == 0) ? pair_q0.size() : pair_q1.size();
            check($sformatf("pairs_left%0d", d), 64'(left), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon(0, if0.out_valid, if0.out_ready, if0.out_bin, if0.out_count, if0.done, if0.busy,
                {if0.peak_bin, if0.peak_count, if0.total_count});
            mon(1, if1.out_valid, if1.out_ready, if1.out_bin, if1.out_count, if1.done, if1.busy,
                {if1.peak_bin, if1.peak_count, if1.total_count});
        end
    end

    function automatic logic [63:0] outs0();
        return 64'({if0.addr, if0.busy, if0.out_valid, if0.out_bin, if0.out_count,
                    if0.peak_bin, if0.peak_count, if0.total_count, if0.done});
    endfunction
    function automatic logic [63:0] outs1();
        return 64'({if1.addr, if1.busy, if1.out_valid, if1.out_bin, if1.out_count,
                    if1.peak_bin, if1.peak_count, if1.total_count, if1.done});
    endfunction

    // Reference model: the sweep reads each bin once; peak is the first bin holding the maximum.
    task automatic expect_sweep();
        int pb, pc, tot;
        pb = 0; pc = 0; tot = 0;
        for (int i = 0; i < NB; i++) begin
            pair_q0.push_back({BW'(i), mem[i]});
            if (mem[i] != 0) pair_q1.push_back({BW'(i), mem[i]});
            if (int'(mem[i]) > pc) begin
                pc = int'(mem[i]);
                pb = i;
            end
            tot += int'(mem[i]);
        end
        sum_q0.push_back({BW'(pb), CW'(pc), SW'(tot)});
        sum_q1.push_back({BW'(pb), CW'(pc), SW'(tot)});
    endtask

    task automatic sweep(input int m, input bit restart);
        int k, k0, k1;
        mode = m;
        expect_sweep();
        @(posedge clk); #1 start_both(1'b1);
        @(posedge clk); #1 start_both(1'b0);
        k = 0; k0 = 0; k1 = 0;
        while ((k0 == 0 || k1 == 0) && k < 2000) begin
            @(negedge clk);
            k++;
            start_both(restart && (k == 20 || k == 41));
            if (if0.done && k0 == 0) k0 = k;
            if (if1.done && k1 == 0) k1 = k;
        end
        start_both(1'b0);
        if (k0 == 0 || k1 == 0) check("sweep_timeout", 64'(k), 64'd0);
        if (m == 0) check("sweep_latency", 64'(k0), 64'd65);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        start_both(1'b0);
        for (int i = 0; i < NB; i++) mem[i] = '0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs0", outs0(), 64'd0);
        check("reset_outs1", outs1(), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Ramp data, ready held high then throttled 1-in-4.
        for (int i = 0; i < NB; i++) mem[i] = CW'(i + 1);
        sweep(0, 1'b0);
        sweep(1, 1'b0);

        // Two equal peaks in otherwise empty histogram.
        for (int i = 0; i < NB; i++) mem[i] = '0;
        mem[3] = CW'(500);
        mem[9] = CW'(500);
        sweep(2, 1'b0);

        // Saturated bins.
        for (int i = 0; i < NB; i++) mem[i] = CW'(1023);
        sweep(0, 1'b0);

        // Random data with start re-pulsed mid-sweep.
        for (int i = 0; i < NB; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(0, 1023));
        sweep(2, 1'b1);

        // Reset while presenting bin 7.
        begin
            int k;
            mode = 0;
            expect_sweep();
            @(posedge clk); #1 start_both(1'b1);
            @(posedge clk); #1 start_both(1'b0);
            k = 0;
            while (!(if0.out_valid && if0.out_bin == BW'(7)) && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (k >= 200) check("bin7_timeout", 64'(k), 64'd0);
            rst = 1'b1;
            #1;
            check("midreset_outs0", outs0(), 64'd0);
            check("midreset_outs1", outs1(), 64'd0);
            pair_q0.delete(); pair_q1.delete();
            sum_q0.delete();  sum_q1.delete();
            repeat (2) @(negedge clk);
            check("midreset_done0", 64'(if0.done), 64'd0);
            @(posedge clk); #1 rst = 1'b0;
            repeat (3) @(negedge clk);
            check("post_reset_outs0", outs0(), 64'd0);
        end

        // Fresh random sweeps after the abort.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < NB; i++)
                mem[i] = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(0, 1023));
            sweep(s % 3, 1'b0);
        end

        check("final_pairs0", 64'(pair_q0.size()), 64'd0);
        check("final_pairs1", 64'(pair_q1.size()), 64'd0);
        check("final_sums", 64'(sum_q0.size() + sum_q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/histo_readout.md
# histo_readout

Downstream readout stage for the run-length histogram block. On a `start` pulse it sweeps bin addresses 0..15 over the histogram read port and captures each 10-bit bin value one cycle after issuing its address. It streams the (bin, count) pairs out over a valid/ready handshake and accumulates the peak bin and the total count for the sweep. It sits between the histogram and the host/report logic, and it is the only driver of the histogram `addr` port.

## Interface
- `NUM_BINS`, 16: bins swept, addressed 0..NUM_BINS-1.
- `COUNT_W`, 10: width of one bin value.
- `SKIP_ZERO`, 0: when 1, bins with count 0 are captured and summed but not presented on the output stream.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a sweep.
- `addr`  out  4  histogram bin address, fed to the histogram `addr` input.
- `hist_data`  in  COUNT_W  histogram bin value, valid one cycle after `addr`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  consumer accepts the pair when high with `out_valid`.
- `out_bin`  out  4  bin index of the presented pair.
- `out_count`  out  COUNT_W  count of the presented pair.
- `peak_bin`  out  4  bin with the largest count in the last completed sweep.
- `peak_count`  out  COUNT_W  count of `peak_bin`.
- `total_count`  out  COUNT_W+4  sum of all bin counts in the last completed sweep.
- `done`  out  1  one-cycle pulse when a sweep completes.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, PRESENT, FINISH.
- IDLE: when `start`=1, clear the bin index, running peak and running sum, then go to ISSUE. In any other state `start` is ignored.
- ISSUE: drive `addr` = bin index (registered), then go to WAIT.
- WAIT: the histogram registers `hist_data` for the issued address, then go to CAPTURE.
- CAPTURE: latch `hist_data` into `out_count` and the bin index into `out_bin`.
  - Add the count to the running sum.
  - Update the running peak if the count is strictly greater than the current peak. Ties keep the lower bin. Peak starts at bin 0, count 0.
  - If SKIP_ZERO=1 and the count is 0: go to ISSUE for the next bin, or to FINISH after the last bin.
  - Otherwise go to PRESENT.
- PRESENT: hold `out_valid`=1 with `out_bin` and `out_count` stable until `out_ready`=1.
  - On acceptance, go to ISSUE for the next bin, or to FINISH if the bin index is NUM_BINS-1.
  - The bin index increments without wrap, because the sweep ends at NUM_BINS-1.
- FINISH: copy the running peak and running sum to `peak_bin`, `peak_count` and `total_count`. Pulse `done` for one cycle, drop `busy`, and return to IDLE.
- Summary outputs hold their values until the next FINISH. They never show partial sweep values.
- Sum width COUNT_W+4 holds 16×1023 = 16368 without overflow. No saturation logic is needed.
- `addr` holds its last driven value in IDLE.

## Timing
- Reset values: `addr`=0, `busy`=0, `out_valid`=0, `out_bin`=0, `out_count`=0, `peak_bin`=0, `peak_count`=0, `total_count`=0, `done`=0; state IDLE.
- Reset asserted mid-sweep:
  - Immediately abandon the sweep and drop `out_valid`.
  - Summary outputs return to 0.
  - No `done` pulse is produced.
- Per-bin cycles with `out_ready` held high:
  - ISSUE (1) + WAIT (1) + CAPTURE (1) + PRESENT (1) = 4 cycles.
  - A full sweep is 64 cycles from `start` to `done` (within ±1 for the FINISH cycle).
  - `done` is asserted in the cycle after the last acceptance.
- Read alignment: `addr` changes at edge k, and `hist_data` is sampled at edge k+2. This matches the histogram's one-cycle registered read.
- Handshake rules:
  - `out_valid` must not drop, and `out_bin`/`out_count` must not change, while `out_ready`=0.
  - `out_valid` does not depend combinationally on `out_ready`.
- `start` and `done` in the same cycle: `start` is ignored, because the FSM is not yet in IDLE.
- Sweeping while the histogram is still being written is legal. Results reflect the values present at each bin's read cycle.

## Test plan
- Histogram preloaded with bin i = i+1, `out_ready`=1, one `start`:
  - 16 pairs (0,1)..(15,16), each accepted 4 cycles apart.
  - Then `peak_bin`=15, `peak_count`=16, `total_count`=136 and a single `done` pulse.
- Same data, `out_ready` toggled 1 cycle high / 3 cycles low:
  - Each pair holds stable while stalled, with no loss or duplication.
  - Same summary as above.
- Bins 3 and 9 = 500, all other bins = 0, SKIP_ZERO=1:
  - Only pairs (3,500) and (9,500) are presented.
  - `peak_bin`=3 (tie resolves to the lower bin), `total_count`=1000.
- All bins = 1023:
  - `total_count`=16368, `peak_bin`=0, `peak_count`=1023.
- `start` pulsed again mid-sweep: ignored; the sweep completes normally with exactly 16 pairs.
- `rst` asserted while in PRESENT at bin 7:
  - All outputs are 0 in the same cycle (asynchronous reset), with no `done` pulse.
  - A later `start` produces a full, correct sweep.
